// File: rtl/jk_ff.sv
// Bank of independent positive-edge JK flip-flops with synchronous active-high reset.
// Each bit holds, clears, sets or toggles according to its own J/K pair.
module jk_ff #(
  parameter int unsigned          WIDTH       = 1,
  parameter logic [WIDTH-1:0]     RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n
);

  // Characteristic equation q+ = J&~q | ~K&q covers hold/reset/set/toggle per bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else begin
      q <= (J & ~q) | (~K & q);
    end
  end

  assign q_n = ~q;

endmodule

// File: tb/tb_jk_ff.sv
// Directed bench for jk_ff: single-bit default instance and a 4-bit instance
// with a non-zero reset value, driven from hand-computed vector tables.
module tb_jk_ff;

  typedef struct {
    logic       rst;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] q;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst1, rst4;
  logic [0:0] j1, k1, q1, qn1;
  logic [3:0] j4, k4, q4, qn4;

  int total = 0;
  int bad   = 0;

  vec_t v1[16];
  vec_t v4[5];

  always #5 clk = ~clk;

  jk_ff dut1 (
    .clk (clk),
    .rst (rst1),
    .J   (j1),
    .K   (k1),
    .q   (q1),
    .q_n (qn1)
  );

  jk_ff #(.WIDTH(4), .RESET_VALUE(4'b1010)) dut4 (
    .clk (clk),
    .rst (rst4),
    .J   (j4),
    .K   (k4),
    .q   (q4),
    .q_n (qn4)
  );

  task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%b want=%b", name, idx, act, exp);
    end
  endtask

  initial begin
    // single-bit: reset, hold/reset/set/toggle, toggle run, reset priority
    v1[0]  = '{1'b1, 4'h1, 4'h1, 4'h0};
    v1[1]  = '{1'b0, 4'h0, 4'h0, 4'h0};
    v1[2]  = '{1'b0, 4'h0, 4'h1, 4'h0};
    v1[3]  = '{1'b0, 4'h1, 4'h0, 4'h1};
    v1[4]  = '{1'b0, 4'h1, 4'h1, 4'h0};
    v1[5]  = '{1'b0, 4'h1, 4'h1, 4'h1};
    v1[6]  = '{1'b0, 4'h1, 4'h1, 4'h0};
    v1[7]  = '{1'b0, 4'h1, 4'h1, 4'h1};
    v1[8]  = '{1'b0, 4'h1, 4'h1, 4'h0};
    v1[9]  = '{1'b0, 4'h0, 4'h0, 4'h0};
    v1[10] = '{1'b0, 4'h0, 4'h0, 4'h0};
    v1[11] = '{1'b0, 4'h1, 4'h0, 4'h1};
    v1[12] = '{1'b1, 4'h1, 4'h0, 4'h0};
    v1[13] = '{1'b0, 4'h1, 4'h0, 4'h1};
    v1[14] = '{1'b0, 4'h0, 4'h0, 4'h1};
    v1[15] = '{1'b0, 4'h0, 4'h1, 4'h0};

    // 4-bit with reset value 1010
    v4[0] = '{1'b1, 4'b0000, 4'b0000, 4'b1010};
    v4[1] = '{1'b0, 4'b0011, 4'b0101, 4'b1011};
    v4[2] = '{1'b0, 4'b1111, 4'b1111, 4'b0100};
    v4[3] = '{1'b0, 4'b0000, 4'b1111, 4'b0000};
    v4[4] = '{1'b1, 4'b1111, 4'b0000, 4'b1010};

    rst1 = 1'b0; j1 = '0; k1 = '0;
    rst4 = 1'b0; j4 = '0; k4 = '0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rst1 = v1[i].rst;
      j1   = v1[i].j[0:0];
      k1   = v1[i].k[0:0];
      @(posedge clk);
      #1;
      check("q1", i, {3'b000, q1}, v1[i].q);
      check("qn1", i, {3'b000, qn1}, {3'b000, ~v1[i].q[0]});
    end

    // q1 is 0 here; a J pulse entirely between edges must not disturb it
    @(negedge clk);
    rst1 = 1'b0; j1 = 1'b0; k1 = 1'b0;
    @(posedge clk);
    #2;
    j1 = 1'b1;
    #2;
    check("pulse_mid", 0, {3'b000, q1}, 4'h0);
    #2;
    j1 = 1'b0;
    @(posedge clk);
    #1;
    check("pulse_after", 0, {3'b000, q1}, 4'h0);
    check("pulse_after_n", 0, {3'b000, qn1}, 4'h1);

    // same check from the set state with a K pulse
    @(negedge clk);
    j1 = 1'b1;
    @(posedge clk);
    #1;
    check("set_before_kpulse", 0, {3'b000, q1}, 4'h1);
    j1 = 1'b0;
    #2;
    k1 = 1'b1;
    #3;
    k1 = 1'b0;
    @(posedge clk);
    #1;
    check("kpulse_after", 0, {3'b000, q1}, 4'h1);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rst4 = v4[i].rst;
      j4   = v4[i].j;
      k4   = v4[i].k;
      @(posedge clk);
      #1;
      check("q4", i, q4, v4[i].q);
      check("qn4", i, qn4, ~v4[i].q);
    end

    // hold after reset release keeps the reset value
    @(negedge clk);
    rst4 = 1'b0; j4 = '0; k4 = '0;
    @(posedge clk);
    #1;
    check("q4_hold", 0, q4, 4'b1010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jk_ff.md
Name: jk_ff

Overview:
- Positive-edge-triggered JK flip-flop bank with synchronous active-high reset. Each bit is an independent JK flip-flop.
- Provides hold, reset-to-0, set-to-1 and toggle storage for control logic and small counters/dividers.
- Width and reset value are parameterized. The default is a single-bit JK flip-flop.

Parameters:
- WIDTH, 1, number of independent JK flip-flop bits (>=1).
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high; sampled on rising clk edge.
- J  input  WIDTH  per-bit J (set) input.
- K  input  WIDTH  per-bit K (reset) input.
- q  output  WIDTH  registered flip-flop state.
- q_n  output  WIDTH  bitwise complement of q (combinational from q).

Behaviour:
- Clocking: one clock (clk). Reset is synchronous and active-high on rst. No asynchronous paths into the state.
- Reset:
  - On a rising clk edge with rst=1, q <= RESET_VALUE and q_n = ~RESET_VALUE, regardless of J/K.
  - rst takes priority over J/K in the same cycle.
  - Mid-operation reset, including mid-toggle sequences, forces RESET_VALUE on that edge.
- Per bit i, on a rising clk edge with rst=0:
  - J=0,K=0: hold, q[i] <= q[i].
  - J=0,K=1: reset, q[i] <= 0.
  - J=1,K=0: set, q[i] <= 1.
  - J=1,K=1: toggle, q[i] <= ~q[i].
- Latency: J/K/rst sampled at edge n appear on q immediately after edge n (one register stage). No combinational path from J/K to q.
- q_n is always exactly ~q, including during and after reset.
- Bits are fully independent: no cross-bit interaction.
- Between edges, q is stable. Changes of J/K between edges have no effect.
- Before the first reset, q is undefined. The bench must apply rst before checking values.
- Power-on initial values (initial blocks) are not used. Reset is the only defined initialization.
- Implementation: a single always block on posedge clk for the state, plus a continuous assign for q_n. Synthesizable; no latches.

Test Plan:
- Reset: rst=1, J=1, K=1 for one edge (WIDTH=1, RESET_VALUE=0) -> q=0, q_n=1 after the edge. Release rst -> state remains 0 until a J/K action.
- Hold/reset/set/toggle sequence: after reset, apply J,K = 0,0 -> 0,1 -> 1,0 -> 1,1, each for one 10-unit clock period (clk toggles every 5) -> q = 0, 0, 1, 0. Checked after each rising edge; q_n always the complement.
- Repeated toggle: J=K=1 held for 4 edges from q=0 -> q = 1, 0, 1, 0. Then J=K=0 for 2 edges -> q stays 0.
- Reset priority mid-operation: q=1 via set, then rst=1 with J=1,K=0 -> q=0 on that edge. Deassert rst with J=1,K=0 -> q=1 next edge.
- Non-edge stability: change J/K between clock edges (e.g., pulse J=1 at t=2 after posedge and remove before the next edge) -> q unchanged.
- Multi-bit (WIDTH=4, RESET_VALUE=4'b1010):
  - rst -> q=1010.
  - Then J=4'b0011, K=4'b0101 -> bit0 toggle, bit1 set, bit2 reset, bit3 hold -> q=1011.
